// File: rtl/aurora_tx_pkt_arb.sv
// Packet-atomic 2:1 AXI-Stream arbiter ahead of the Aurora TX user interface.
// s1 (control) wins at packet boundaries, bounded by an s0 starvation guard; output is a 2-entry skid stage.
module aurora_tx_pkt_arb #(
   parameter int DATA_WD      = 64,
   parameter int MAX_S1_BURST = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   cfg_rst,
   input  logic [DATA_WD-1:0]     s0_axis_tdata,
   input  logic [DATA_WD/8-1:0]   s0_axis_tkeep,
   input  logic                   s0_axis_tvalid,
   output logic                   s0_axis_tready,
   input  logic                   s0_axis_tlast,
   input  logic [DATA_WD-1:0]     s1_axis_tdata,
   input  logic [DATA_WD/8-1:0]   s1_axis_tkeep,
   input  logic                   s1_axis_tvalid,
   output logic                   s1_axis_tready,
   input  logic                   s1_axis_tlast,
   output logic [DATA_WD-1:0]     m_axis_tdata,
   output logic [DATA_WD/8-1:0]   m_axis_tkeep,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic                   m_axis_tlast,
   output logic [31:0]            s0_pkt_cnt,
   output logic [31:0]            s1_pkt_cnt,
   output logic [1:0]             arb_state
);

   localparam int              KEEP_WD  = DATA_WD / 8;
   localparam int              BW       = $clog2(MAX_S1_BURST + 2);
   localparam logic [BW-1:0]   MAX_B    = BW'(MAX_S1_BURST);
   localparam bit              GUARD_EN = (MAX_S1_BURST != 0);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOCK0 = 2'd1,
      ST_LOCK1 = 2'd2,
      ST_BAD   = 2'd3
   } state_e;

   state_e               state_q;
   logic [BW-1:0]        burst_q;
   logic                 in_ready_q;

   logic                 main_valid_q;
   logic [DATA_WD-1:0]   main_data_q;
   logic [KEEP_WD-1:0]   main_keep_q;
   logic                 main_last_q;
   logic                 main_src_q;

   logic                 skid_valid_q;
   logic                 skid_valid_d;
   logic [DATA_WD-1:0]   skid_data_q;
   logic [KEEP_WD-1:0]   skid_keep_q;
   logic                 skid_last_q;
   logic                 skid_src_q;

   logic [31:0]          s0_cnt_q;
   logic [31:0]          s1_cnt_q;

   logic                 guard_s;
   logic                 grant0_s;
   logic                 grant1_s;
   logic                 in_valid_s;
   logic [DATA_WD-1:0]   in_data_s;
   logic [KEEP_WD-1:0]   in_keep_s;
   logic                 in_last_s;
   logic                 acc_s;
   logic                 out_fire_s;

   // Grant selection: combinational in IDLE so the first beat goes through without a bubble.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      guard_s  = GUARD_EN && (burst_q == MAX_B) && s0_axis_tvalid;
      case (state_q)
         ST_IDLE: begin
            if (s1_axis_tvalid && !guard_s) begin
               grant1_s = 1'b1;
            end else if (s0_axis_tvalid) begin
               grant0_s = 1'b1;
            end else begin
               grant0_s = 1'b0;
               grant1_s = 1'b0;
            end
         end
         ST_LOCK0: grant0_s = 1'b1;
         ST_LOCK1: grant1_s = 1'b1;
         default: begin
            grant0_s = 1'b0;
            grant1_s = 1'b0;
         end
      endcase
   end

   // Input mux for the granted stream.
   always_comb begin
      in_valid_s = 1'b0;
      in_data_s  = '0;
      in_keep_s  = '0;
      in_last_s  = 1'b0;
      if (grant1_s) begin
         in_valid_s = s1_axis_tvalid;
         in_data_s  = s1_axis_tdata;
         in_keep_s  = s1_axis_tkeep;
         in_last_s  = s1_axis_tlast;
      end else if (grant0_s) begin
         in_valid_s = s0_axis_tvalid;
         in_data_s  = s0_axis_tdata;
         in_keep_s  = s0_axis_tkeep;
         in_last_s  = s0_axis_tlast;
      end else begin
         in_valid_s = 1'b0;
      end
   end

   assign acc_s      = in_valid_s && in_ready_q;
   assign out_fire_s = main_valid_q && m_axis_tready;

   // Skid occupancy for next cycle; in_ready is registered from it.
   always_comb begin
      skid_valid_d = 1'b0;
      if (skid_valid_q) begin
         skid_valid_d = !out_fire_s;
      end else begin
         skid_valid_d = acc_s && main_valid_q && !out_fire_s;
      end
   end

   // Arbitration FSM and s1 burst counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         burst_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (acc_s && !in_last_s) begin
                  state_q <= grant1_s ? ST_LOCK1 : ST_LOCK0;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LOCK0, ST_LOCK1: begin
               if (acc_s && in_last_s) begin
                  state_q <= ST_IDLE;
               end else begin
                  state_q <= state_q;
               end
            end
            default: state_q <= ST_IDLE;
         endcase

         // Burst only grows while s0 is actually waiting; an idle s0 forgives the history.
         if (acc_s && in_last_s && grant0_s) begin
            burst_q <= '0;
         end else if (acc_s && in_last_s && grant1_s) begin
            if (!s0_axis_tvalid) begin
               burst_q <= '0;
            end else if (burst_q < MAX_B) begin
               burst_q <= burst_q + BW'(1);
            end else begin
               burst_q <= burst_q;
            end
         end else begin
            burst_q <= burst_q;
         end
      end
   end

   // Output skid stage: main register drives m_axis, skid catches the beat in flight during a stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         in_ready_q   <= 1'b0;
         main_valid_q <= 1'b0;
         main_data_q  <= '0;
         main_keep_q  <= '0;
         main_last_q  <= 1'b0;
         main_src_q   <= 1'b0;
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_keep_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_src_q   <= 1'b0;
      end else begin
         in_ready_q   <= !skid_valid_d;
         skid_valid_q <= skid_valid_d;
         if (skid_valid_q) begin
            if (out_fire_s) begin
               main_valid_q <= 1'b1;
               main_data_q  <= skid_data_q;
               main_keep_q  <= skid_keep_q;
               main_last_q  <= skid_last_q;
               main_src_q   <= skid_src_q;
            end
         end else if (acc_s && (!main_valid_q || out_fire_s)) begin
            main_valid_q <= 1'b1;
            main_data_q  <= in_data_s;
            main_keep_q  <= in_keep_s;
            main_last_q  <= in_last_s;
            main_src_q   <= grant1_s;
         end else if (acc_s) begin
            skid_data_q  <= in_data_s;
            skid_keep_q  <= in_keep_s;
            skid_last_q  <= in_last_s;
            skid_src_q   <= grant1_s;
         end else if (out_fire_s) begin
            main_valid_q <= 1'b0;
         end
      end
   end

   // Packet statistics on the output tlast beat; cfg_rst beats a coincident increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s0_cnt_q <= 32'd0;
         s1_cnt_q <= 32'd0;
      end else if (cfg_rst) begin
         s0_cnt_q <= 32'd0;
         s1_cnt_q <= 32'd0;
      end else if (out_fire_s && main_last_q) begin
         if (main_src_q) begin
            s1_cnt_q <= s1_cnt_q + 32'd1;
         end else begin
            s0_cnt_q <= s0_cnt_q + 32'd1;
         end
      end
   end

   assign s0_axis_tready = in_ready_q && grant0_s;
   assign s1_axis_tready = in_ready_q && grant1_s;
   assign m_axis_tvalid  = main_valid_q;
   assign m_axis_tdata   = main_data_q;
   assign m_axis_tkeep   = main_keep_q;
   assign m_axis_tlast   = main_last_q;
   assign s0_pkt_cnt     = s0_cnt_q;
   assign s1_pkt_cnt     = s1_cnt_q;
   assign arb_state      = state_q;

endmodule

// File: tb/tb_aurora_tx_pkt_arb.sv
// Directed bench for aurora_tx_pkt_arb: each task drives one scenario and checks hand-derived values.
module tb_aurora_tx_pkt_arb;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, cfg_rst;
   logic [63:0] s0_d, s1_d, m_d;
   logic [7:0]  s0_k, s1_k, m_k;
   logic        s0_v, s0_r, s0_l, s1_v, s1_r, s1_l, m_v, m_r, m_l;
   logic [31:0] c0, c1;
   logic [1:0]  st;

   logic [63:0] zm_d;
   logic [7:0]  zm_k;
   logic        z0_v, z1_v, z0_r, z1_r, zm_v, zm_l;
   logic [31:0] zc0, zc1;
   logic [1:0]  zst;

   aurora_tx_pkt_arb #(.DATA_WD(64), .MAX_S1_BURST(4)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst),
      .s0_axis_tdata(s0_d), .s0_axis_tkeep(s0_k), .s0_axis_tvalid(s0_v),
      .s0_axis_tready(s0_r), .s0_axis_tlast(s0_l),
      .s1_axis_tdata(s1_d), .s1_axis_tkeep(s1_k), .s1_axis_tvalid(s1_v),
      .s1_axis_tready(s1_r), .s1_axis_tlast(s1_l),
      .m_axis_tdata(m_d), .m_axis_tkeep(m_k), .m_axis_tvalid(m_v),
      .m_axis_tready(m_r), .m_axis_tlast(m_l),
      .s0_pkt_cnt(c0), .s1_pkt_cnt(c1), .arb_state(st)
   );

   aurora_tx_pkt_arb #(.DATA_WD(64), .MAX_S1_BURST(0)) dut_z (
      .clk(clk), .rst_n(rst_n), .cfg_rst(cfg_rst),
      .s0_axis_tdata(64'h0000_0000_0000_000A), .s0_axis_tkeep(8'hFF), .s0_axis_tvalid(z0_v),
      .s0_axis_tready(z0_r), .s0_axis_tlast(1'b1),
      .s1_axis_tdata(64'h0000_0000_0000_000B), .s1_axis_tkeep(8'hFF), .s1_axis_tvalid(z1_v),
      .s1_axis_tready(z1_r), .s1_axis_tlast(1'b1),
      .m_axis_tdata(zm_d), .m_axis_tkeep(zm_k), .m_axis_tvalid(zm_v),
      .m_axis_tready(1'b1), .m_axis_tlast(zm_l),
      .s0_pkt_cnt(zc0), .s1_pkt_cnt(zc1), .arb_state(zst)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        l;
   } beat_t;

   beat_t s0_q[$], s1_q[$], out_q[$];
   int    acc_src[$], acc_cyc[$], out_cyc[$];
   int    cyc_n, n_cmp, n_err, s1_wait, z_g0, z_g1, z_bad;
   logic        obs_v, obs_r, obs_l;
   logic [63:0] obs_d;

   function automatic beat_t mk(logic [63:0] d, logic [7:0] k, logic l);
      beat_t b;
      b.d = d; b.k = k; b.l = l;
      return b;
   endfunction

   // One clock: drive sources from their queues, observe, cross the edge, retire accepted beats.
   task automatic cyc();
      logic a0, a1;
      s0_v = (s0_q.size() > 0);
      s1_v = (s1_q.size() > 0);
      {s0_d, s0_k, s0_l} = s0_v ? s0_q[0] : '0;
      {s1_d, s1_k, s1_l} = s1_v ? s1_q[0] : '0;
      #1;
      obs_v = m_v; obs_r = m_r; obs_d = m_d; obs_l = m_l;
      if (m_v && m_r) begin
         out_q.push_back(mk(m_d, m_k, m_l));
         out_cyc.push_back(cyc_n);
      end
      a0 = s0_v && s0_r;
      a1 = s1_v && s1_r;
      if (s1_v && !s1_r) s1_wait++;
      if (z0_r) z_g0++;
      if (z1_r) z_g1++;
      if (zm_v && zm_d !== 64'h0000_0000_0000_000B) z_bad++;
      @(posedge clk);
      #1;
      if (a0) begin void'(s0_q.pop_front()); acc_src.push_back(0); acc_cyc.push_back(cyc_n); end
      if (a1) begin void'(s1_q.pop_front()); acc_src.push_back(1); acc_cyc.push_back(cyc_n); end
      cyc_n++;
   endtask

   task automatic clr();
      out_q.delete(); acc_src.delete(); acc_cyc.delete(); out_cyc.delete();
      cyc_n = 0; s1_wait = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
      s0_q.delete(); s1_q.delete();
      cyc();
      clr();
   endtask

   task automatic test_reset();
      s0_q.push_back(mk(64'h1, 8'hFF, 1'b1));
      s1_q.push_back(mk(64'h2, 8'hFF, 1'b1));
      m_r = 1'b1;
      rst_n = 1'b0;
      cyc(); cyc();
      n_cmp++; if (m_v !== 1'b0)  begin n_err++; $display("FAIL reset_tvalid: got %b want 0", m_v); end
      n_cmp++; if (m_d !== 64'h0) begin n_err++; $display("FAIL reset_tdata: got %h want 0", m_d); end
      n_cmp++; if (m_k !== 8'h0)  begin n_err++; $display("FAIL reset_tkeep: got %h want 0", m_k); end
      n_cmp++; if (m_l !== 1'b0)  begin n_err++; $display("FAIL reset_tlast: got %b want 0", m_l); end
      n_cmp++; if (s0_r !== 1'b0 || s1_r !== 1'b0) begin n_err++; $display("FAIL reset_tready: got %b%b want 00", s0_r, s1_r); end
      n_cmp++; if (c0 !== 32'd0 || c1 !== 32'd0) begin n_err++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", c0, c1); end
      n_cmp++; if (st !== 2'd0)   begin n_err++; $display("FAIL reset_state: got %0d want 0", st); end
      rst_n = 1'b1;
      s0_q.delete(); s1_q.delete();
      cyc();
      clr();
   endtask

   task automatic test_s1_packet();
      beat_t e[2];
      do_reset();
      m_r = 1'b1;
      e[0] = mk(64'h0000_0000_55aa_0001, 8'hFF, 1'b0);
      e[1] = mk(64'h0000_0000_0000_0001, 8'h3F, 1'b1);
      s1_q.push_back(e[0]); s1_q.push_back(e[1]);
      for (int i = 0; i < 20 && out_q.size() < 2; i++) cyc();
      n_cmp++; if (out_q.size() != 2) begin n_err++; $display("FAIL s1pkt_count: got %0d beats want 2", out_q.size()); end
      for (int i = 0; i < 2 && i < out_q.size(); i++) begin
         n_cmp++;
         if (out_q[i] !== e[i]) begin n_err++; $display("FAIL s1pkt_beat%0d: got %h want %h", i, out_q[i], e[i]); end
      end
      if (acc_cyc.size() > 0 && out_cyc.size() > 0) begin
         n_cmp++; if (acc_cyc[0] != 0) begin n_err++; $display("FAIL s1pkt_first_accept: got cycle %0d want 0", acc_cyc[0]); end
         n_cmp++; if (out_cyc[0] != acc_cyc[0] + 1) begin n_err++; $display("FAIL s1pkt_latency: got %0d want %0d", out_cyc[0], acc_cyc[0] + 1); end
      end else begin
         n_cmp++; n_err++; $display("FAIL s1pkt_latency: no acceptance or output seen");
      end
      n_cmp++; if (c1 !== 32'd1 || c0 !== 32'd0) begin n_err++; $display("FAIL s1pkt_cnt: got %0d/%0d want 0/1", c0, c1); end
   endtask

   task automatic test_no_interleave();
      beat_t e[$];
      bit pushed = 1'b0;
      do_reset();
      m_r = 1'b1;
      for (int i = 0; i < 8; i++) begin
         s0_q.push_back(mk(64'h2000 + 64'(i), 8'hFF, (i == 7)));
         e.push_back(mk(64'h2000 + 64'(i), 8'hFF, (i == 7)));
      end
      e.push_back(mk(64'h3000, 8'hFF, 1'b0));
      e.push_back(mk(64'h3001, 8'hFF, 1'b1));
      for (int i = 0; i < 60 && out_q.size() < 10; i++) begin
         if (!pushed && acc_src.size() == 3) begin
            s1_q.push_back(e[8]); s1_q.push_back(e[9]);
            pushed = 1'b1;
         end
         cyc();
      end
      n_cmp++; if (out_q.size() != 10) begin n_err++; $display("FAIL lock_count: got %0d beats want 10", out_q.size()); end
      for (int i = 0; i < 10 && i < out_q.size(); i++) begin
         n_cmp++;
         if (out_q[i] !== e[i]) begin n_err++; $display("FAIL lock_beat%0d: got %h want %h", i, out_q[i], e[i]); end
      end
      for (int i = 0; i < 10 && i < acc_src.size(); i++) begin
         n_cmp++;
         if (acc_src[i] != ((i < 8) ? 0 : 1)) begin n_err++; $display("FAIL lock_src%0d: got %0d want %0d", i, acc_src[i], (i < 8) ? 0 : 1); end
      end
      n_cmp++; if (s1_wait != 5) begin n_err++; $display("FAIL lock_s1_wait: got %0d cycles want 5", s1_wait); end
   endtask

   task automatic test_guard();
      int    es[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
      logic [63:0] ed[10];
      do_reset();
      m_r = 1'b1;
      for (int i = 0; i < 10; i++) begin
         s0_q.push_back(mk(64'h4000 + 64'(i), 8'hFF, 1'b1));
         s1_q.push_back(mk(64'h5000 + 64'(i), 8'hFF, 1'b1));
      end
      ed = '{64'h5000, 64'h5001, 64'h5002, 64'h5003, 64'h4000,
             64'h5004, 64'h5005, 64'h5006, 64'h5007, 64'h4001};
      for (int i = 0; i < 40 && out_q.size() < 10; i++) cyc();
      n_cmp++; if (out_q.size() < 10) begin n_err++; $display("FAIL guard_count: got %0d beats want 10", out_q.size()); end
      for (int i = 0; i < 10 && i < acc_src.size(); i++) begin
         n_cmp++;
         if (acc_src[i] != es[i]) begin n_err++; $display("FAIL guard_src%0d: got %0d want %0d", i, acc_src[i], es[i]); end
      end
      for (int i = 0; i < 10 && i < out_q.size(); i++) begin
         n_cmp++;
         if (out_q[i].d !== ed[i]) begin n_err++; $display("FAIL guard_data%0d: got %h want %h", i, out_q[i].d, ed[i]); end
      end
   endtask

   task automatic test_guard_off();
      do_reset();
      z_g0 = 0; z_g1 = 0; z_bad = 0;
      z0_v = 1'b1; z1_v = 1'b1;
      repeat (20) cyc();
      n_cmp++; if (z_g0 != 0)  begin n_err++; $display("FAIL noguard_s0_grant: got %0d want 0", z_g0); end
      n_cmp++; if (z_g1 != 20) begin n_err++; $display("FAIL noguard_s1_grant: got %0d want 20", z_g1); end
      n_cmp++; if (z_bad != 0) begin n_err++; $display("FAIL noguard_data: got %0d non-s1 beats want 0", z_bad); end
      z1_v = 1'b0;
      z_g0 = 0;
      cyc();
      n_cmp++; if (z_g0 != 1)  begin n_err++; $display("FAIL noguard_s0_after: got %0d want 1", z_g0); end
      z0_v = 1'b0;
   endtask

   task automatic test_backpressure();
      logic        pv = 1'b0, pr = 1'b0, pl = 1'b0;
      logic [63:0] pd = '0;
      int          occ, max_occ = 0;
      do_reset();
      for (int i = 0; i < 16; i++) s0_q.push_back(mk(64'h6000 + 64'(i), 8'hFF, (i == 15)));
      for (int k = 0; k < 100 && out_q.size() < 16; k++) begin
         m_r = (k % 4 == 0) || (k % 4 == 3);
         cyc();
         if (pv && !pr) begin
            n_cmp++;
            if (obs_v !== 1'b1 || obs_d !== pd || obs_l !== pl) begin
               n_err++; $display("FAIL bp_stable: got v=%b d=%h want v=1 d=%h", obs_v, obs_d, pd);
            end
         end
         pv = obs_v; pr = obs_r; pd = obs_d; pl = obs_l;
         occ = acc_src.size() - out_q.size();
         if (occ > max_occ) max_occ = occ;
      end
      m_r = 1'b1;
      n_cmp++; if (out_q.size() != 16) begin n_err++; $display("FAIL bp_count: got %0d beats want 16", out_q.size()); end
      for (int i = 0; i < 16 && i < out_q.size(); i++) begin
         n_cmp++;
         if (out_q[i].d !== 64'h6000 + 64'(i) || out_q[i].l !== (i == 15)) begin
            n_err++; $display("FAIL bp_beat%0d: got %h last=%b want %h", i, out_q[i].d, out_q[i].l, 64'h6000 + 64'(i));
         end
      end
      n_cmp++; if (max_occ != 2) begin n_err++; $display("FAIL bp_occupancy: got %0d want 2", max_occ); end
   endtask

   task automatic test_cfg_rst();
      bit done = 1'b0, hit;
      do_reset();
      m_r = 1'b1;
      for (int i = 0; i < 5; i++) s0_q.push_back(mk(64'h7000 + 64'(i), 8'hFF, 1'b1));
      for (int i = 0; i < 30 && out_q.size() < 5; i++) cyc();
      n_cmp++; if (c0 !== 32'd5) begin n_err++; $display("FAIL cfg_pre_cnt: got %0d want 5", c0); end
      s0_q.push_back(mk(64'h7005, 8'hFF, 1'b1));
      for (int i = 0; i < 20 && !done; i++) begin
         cfg_rst = m_v && m_r && m_l;
         hit = cfg_rst;
         cyc();
         cfg_rst = 1'b0;
         if (hit) done = 1'b1;
      end
      n_cmp++; if (!done) begin n_err++; $display("FAIL cfg_hit: got no tlast beat want one"); end
      n_cmp++; if (c0 !== 32'd0) begin n_err++; $display("FAIL cfg_cnt: got %0d want 0", c0); end
      n_cmp++; if (out_q.size() != 6 || out_q[out_q.size()-1].d !== 64'h7005) begin
         n_err++; $display("FAIL cfg_flow: got %0d beats want 6 ending 7005", out_q.size());
      end
      s0_q.push_back(mk(64'h7006, 8'hFF, 1'b1));
      for (int i = 0; i < 20 && out_q.size() < 7; i++) cyc();
      n_cmp++; if (c0 !== 32'd1) begin n_err++; $display("FAIL cfg_post_cnt: got %0d want 1", c0); end
      n_cmp++; if (st !== 2'd0)  begin n_err++; $display("FAIL cfg_state: got %0d want 0", st); end
   endtask

   task automatic test_mid_reset();
      do_reset();
      m_r = 1'b1;
      s1_q.push_back(mk(64'h8000, 8'hFF, 1'b1));
      for (int i = 0; i < 20 && out_q.size() < 1; i++) cyc();
      n_cmp++; if (c1 !== 32'd1) begin n_err++; $display("FAIL mid_pre_cnt: got %0d want 1", c1); end
      m_r = 1'b0;
      for (int i = 0; i < 4; i++) s0_q.push_back(mk(64'h8100 + 64'(i), 8'hFF, (i == 3)));
      cyc(); cyc(); cyc();
      n_cmp++; if (st !== 2'd1) begin n_err++; $display("FAIL mid_lock_state: got %0d want 1", st); end
      rst_n = 1'b0;
      cyc();
      n_cmp++; if (m_v !== 1'b0 || m_d !== 64'h0 || m_k !== 8'h0 || m_l !== 1'b0) begin
         n_err++; $display("FAIL mid_outputs: got v=%b d=%h k=%h l=%b want all 0", m_v, m_d, m_k, m_l);
      end
      n_cmp++; if (st !== 2'd0) begin n_err++; $display("FAIL mid_state: got %0d want 0", st); end
      n_cmp++; if (c0 !== 32'd0 || c1 !== 32'd0) begin n_err++; $display("FAIL mid_cnt: got %0d/%0d want 0/0", c0, c1); end
      n_cmp++; if (s0_r !== 1'b0) begin n_err++; $display("FAIL mid_tready: got %b want 0", s0_r); end
      rst_n = 1'b1;
      s0_q.delete(); s1_q.delete();
      cyc();
      clr();
      m_r = 1'b1;
      s1_q.push_back(mk(64'h8200, 8'hFF, 1'b0));
      s1_q.push_back(mk(64'h8201, 8'hFF, 1'b1));
      for (int i = 0; i < 20 && out_q.size() < 2; i++) cyc();
      n_cmp++; if (out_q.size() != 2) begin n_err++; $display("FAIL mid_fresh_count: got %0d want 2", out_q.size()); end
      for (int i = 0; i < 2 && i < out_q.size(); i++) begin
         n_cmp++;
         if (out_q[i].d !== 64'h8200 + 64'(i) || out_q[i].l !== (i == 1)) begin
            n_err++; $display("FAIL mid_fresh_beat%0d: got %h want %h", i, out_q[i].d, 64'h8200 + 64'(i));
         end
      end
      n_cmp++; if (c1 !== 32'd1) begin n_err++; $display("FAIL mid_fresh_cnt: got %0d want 1", c1); end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1);
   end

   initial begin
      n_cmp = 0; n_err = 0;
      rst_n = 1'b0; cfg_rst = 1'b0; m_r = 1'b0;
      z0_v = 1'b0; z1_v = 1'b0;
      s0_v = 1'b0; s0_d = '0; s0_k = '0; s0_l = 1'b0;
      s1_v = 1'b0; s1_d = '0; s1_k = '0; s1_l = 1'b0;
      z_g0 = 0; z_g1 = 0; z_bad = 0;
      clr();
      @(posedge clk);
      #1;
      test_reset();
      test_s1_packet();
      test_no_interleave();
      test_guard();
      test_guard_off();
      test_backpressure();
      test_cfg_rst();
      test_mid_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/aurora_tx_pkt_arb.md
Name: aurora_tx_pkt_arb

Overview:
- Packet-atomic 2:1 AXI-Stream arbiter directly upstream of the Aurora TX user interface.
- Merges the bulk acquisition data stream (s0) with the control/end-packet stream (s1, e.g. the 2-beat EDS end packet) onto one Aurora TX stream (m).
- s1 has priority at packet boundaries, with a starvation guard for s0.
- Once granted, a packet is never interleaved; output is a registered skid stage at full throughput.

Parameters:
- DATA_WD, 64, data width in bits; tkeep width is DATA_WD/8.
- MAX_S1_BURST, 4, max consecutive s1 packets granted while s0_axis_tvalid is pending; 0 disables the guard (pure s1 priority).

Ports:
- clk  in  1  single clock
- rst_n  in  1  synchronous active-low reset
- cfg_rst  in  1  synchronous clear of statistics counters only
- s0_axis_tdata  in  DATA_WD  bulk data
- s0_axis_tkeep  in  DATA_WD/8  byte enables
- s0_axis_tvalid  in  1
- s0_axis_tready  out  1
- s0_axis_tlast  in  1
- s1_axis_tdata / s1_axis_tkeep / s1_axis_tvalid / s1_axis_tready / s1_axis_tlast  same widths/directions as s0; control packets
- m_axis_tdata  out  DATA_WD
- m_axis_tkeep  out  DATA_WD/8
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- m_axis_tlast  out  1
- s0_pkt_cnt  out  32  s0 packets forwarded (counted on the output tlast beat)
- s1_pkt_cnt  out  32  s1 packets forwarded
- arb_state  out  2  current FSM state, debug

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - FSM goes to IDLE; burst counter = 0; skid stage empty.
  - m_axis_tvalid=0, tdata=0, tkeep=0, tlast=0.
  - s0/s1_axis_tready=0 during reset; both counters = 0.
- FSM states: IDLE=0, LOCK0=1, LOCK1=2 (3 is unused and recovers to IDLE).
- IDLE: grant is combinational, so the first beat is accepted in the same cycle with no bubble.
  - s1 is selected if s1_axis_tvalid, unless the guard trips.
  - Guard trips when MAX_S1_BURST!=0, burst_cnt==MAX_S1_BURST and s0_axis_tvalid=1; s0 is then selected.
  - Otherwise s0 is selected if s0_axis_tvalid.
  - On an accepted first beat: if tlast=1, stay in IDLE; else go to LOCK0 or LOCK1.
- LOCK0 / LOCK1: only the locked input may be accepted.
  - An accepted beat with tlast=1 returns the FSM to IDLE.
  - The other input's tready is 0 throughout the lock.
- Burst counter:
  - Increments on each accepted s1 tlast beat while s0_axis_tvalid=1.
  - Clears on any accepted s0 tlast beat, and when s0_axis_tvalid=0 at an s1 tlast.
  - Saturates at MAX_S1_BURST.
- Skid stage: a 2-entry registered buffer (main + skid).
  - Internal in_ready = !skid_full, registered.
  - s*_axis_tready = in_ready AND grant for that input.
  - Latency is 1 clk from input acceptance to m_axis_tvalid; sustained throughput is 1 beat/clk with m_axis_tready held high.
- Output stability: while m_axis_tvalid=1 and m_axis_tready=0, m_axis_tdata/tkeep/tlast stay stable. Beats are never dropped, duplicated or reordered.
- tkeep is passed through unmodified; the block does no data inspection (a 55aa header is forwarded as-is).
- Counters:
  - Increment on m_axis_tvalid && m_axis_tready && m_axis_tlast, attributed to the beat's source via a stored source tag.
  - Wrap modulo 2^32.
  - cfg_rst clears them to 0; cfg_rst takes precedence over a simultaneous increment.
  - cfg_rst does not affect the FSM or data path.
- Both inputs valid in IDLE in the same cycle: s1 wins (subject to the guard).
- A packet arriving on the non-granted input mid-lock waits with tready=0; its tvalid/data are held by upstream.
- rst_n asserted mid-packet: in-flight and buffered beats are discarded. Upstream sources must also be reset; no partial-packet recovery is performed.

Test Plan:
1. s1 sends 2-beat packet (0x0000_0000_55aa_0001, then 0x…0001 with tlast), s0 idle, m_tready=1 -> m outputs the same 2 beats starting 1 clk after acceptance; tlast on beat 2; s1_pkt_cnt=1.
2. s0 8-beat packet in progress at beat 3 when s1 asserts valid -> s1_tready stays 0 until s0 tlast is accepted. Output is 8 contiguous s0 beats, then the s1 packet; no interleave.
3. Both valid in IDLE, each with 1-beat packets, continuous -> s1 gets 4 packets, then s0 gets 1, repeating (MAX_S1_BURST=4). With MAX_S1_BURST=0, s0 never granted while s1 valid.
4. Backpressure: m_tready toggles 1,0,0,1,… during a 16-beat s0 packet with incrementing data -> all 16 beats emerge in order, no loss or duplication. tdata is stable during stalls; input tready drops within 1 clk of the skid filling.
5. cfg_rst pulsed in the same cycle as an output tlast, counters at 5 -> counter = 0, not 1. FSM and data flow are unaffected.
6. rst_n low for 1 clk mid-packet -> all outputs return to reset values next cycle; arb_state=0; counters=0. A fresh packet after release is forwarded correctly.
